// File: rtl/mmio_regfile.sv
// rtl/mmio_regfile.sv - PSL MMIO register file: status, W1C sticky and control banks with parity and fixed-latency ack.
// Optional MMIO_SNAPSHOT_EN: a status-0 read freezes all status registers for coherent multi-register reads.
module mmio_regfile #(
  parameter int          NUM_STATUS  = 16,
  parameter int          NUM_STICKY  = 2,
  parameter int          NUM_CTRL    = 4,
  parameter logic [23:0] STATUS_BASE = 24'h000100,
  parameter logic [23:0] STICKY_BASE = 24'h000200,
  parameter logic [23:0] CTRL_BASE   = 24'h000300
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mmio_valid,
  input  logic                       mmio_read,
  input  logic                       mmio_dw,
  input  logic [23:0]                mmio_addr,
  input  logic                       mmio_addr_par,
  input  logic [63:0]                mmio_wdata,
  input  logic                       mmio_wdata_par,
  input  logic [NUM_STATUS*64-1:0]   status_in,
  input  logic [NUM_STICKY*64-1:0]   sticky_set,
  output logic                       mmio_ack,
  output logic [63:0]                mmio_rdata,
  output logic                       mmio_rdata_par,
  output logic [NUM_CTRL*64-1:0]     ctrl_out,
  output logic [NUM_CTRL-1:0]        ctrl_pulse,
  output logic [NUM_STICKY*64-1:0]   sticky_out,
  output logic [2:0]                 mmio_errors
);

  typedef enum logic [1:0] {BANK_NONE, BANK_STAT, BANK_STKY, BANK_CTRL} bank_t;

  logic [63:0] stat_arr [NUM_STATUS];
  logic [63:0] ctrl_q   [NUM_CTRL];
  logic [63:0] stky_q   [NUM_STICKY];

  for (genvar g = 0; g < NUM_STATUS; g++) begin : g_stat
    assign stat_arr[g] = status_in[g*64 +: 64];
  end
  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_out[g*64 +: 64] = ctrl_q[g];
  end
  for (genvar g = 0; g < NUM_STICKY; g++) begin : g_stky
    assign sticky_out[g*64 +: 64] = stky_q[g];
  end

  // S1: raw request capture
  logic        s1_v, s1_read, s1_dw, s1_apar, s1_dpar;
  logic [23:0] s1_addr;
  logic [63:0] s1_wdata;
  logic        s2_v, s3_v;
  logic        busy, ovl;

  assign busy = s1_v | s2_v | s3_v;
  assign ovl  = mmio_valid & busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v <= 1'b0;
    end else begin
      s1_v <= mmio_valid & ~busy;
    end
    if (mmio_valid & ~busy) begin
      s1_read  <= mmio_read;
      s1_dw    <= mmio_dw;
      s1_addr  <= mmio_addr;
      s1_apar  <= mmio_addr_par;
      s1_wdata <= mmio_wdata;
      s1_dpar  <= mmio_wdata_par;
    end
  end

  // S2: address decode and parity check (bit 23 only picks the 32-bit half)
  logic [22:0] off_s, off_k, off_c;
  logic        hit_s, hit_k, hit_c;
  bank_t       dec_bank;
  logic [5:0]  dec_idx;
  logic        dec_aerr, dec_derr;

  always_comb begin
    off_s = s1_addr[22:0] - STATUS_BASE[22:0];
    off_k = s1_addr[22:0] - STICKY_BASE[22:0];
    off_c = s1_addr[22:0] - CTRL_BASE[22:0];
    hit_s = (s1_addr[22:0] >= STATUS_BASE[22:0]) && !off_s[0] &&
            ({10'd0, off_s[22:1]} < NUM_STATUS);
    hit_k = (s1_addr[22:0] >= STICKY_BASE[22:0]) && !off_k[0] &&
            ({10'd0, off_k[22:1]} < NUM_STICKY);
    hit_c = (s1_addr[22:0] >= CTRL_BASE[22:0]) && !off_c[0] &&
            ({10'd0, off_c[22:1]} < NUM_CTRL);
    dec_bank = BANK_NONE;
    dec_idx  = 6'd0;
    if (hit_s) begin
      dec_bank = BANK_STAT;
      dec_idx  = off_s[6:1];
    end else if (hit_k) begin
      dec_bank = BANK_STKY;
      dec_idx  = off_k[6:1];
    end else if (hit_c) begin
      dec_bank = BANK_CTRL;
      dec_idx  = off_c[6:1];
    end
    dec_aerr = ~^{s1_addr, s1_apar};
    dec_derr = ~s1_read & ~^{s1_wdata, s1_dpar};
  end

  logic        s2_read, s2_dw, s2_half, s2_aerr, s2_derr;
  bank_t       s2_bank;
  logic [5:0]  s2_idx;
  logic [63:0] s2_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_v <= 1'b0;
    end else begin
      s2_v <= s1_v;
    end
    s2_read  <= s1_read;
    s2_dw    <= s1_dw;
    s2_half  <= s1_addr[23];
    s2_bank  <= dec_bank;
    s2_idx   <= dec_idx;
    s2_wdata <= s1_wdata;
    s2_aerr  <= dec_aerr;
    s2_derr  <= dec_derr;
  end

  // Status value captured on the way into S3
  logic [63:0] stat_live, stat_val;

  always_comb begin
    stat_live = 64'd0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (s2_idx == 6'(i)) stat_live = stat_arr[i];
    end
  end

`ifdef MMIO_SNAPSHOT_EN
  logic [63:0] snap_q [NUM_STATUS];
  logic [63:0] snap_sel;
  logic        snap_take;

  always_comb begin
    snap_take = s2_v & s2_read & (s2_bank == BANK_STAT) & (s2_idx == 6'd0) & ~s2_aerr;
    snap_sel  = 64'd0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (s2_idx == 6'(i)) snap_sel = snap_q[i];
    end
    stat_val = snap_take ? stat_live : snap_sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATUS; i++) snap_q[i] <= 64'd0;
    end else if (snap_take) begin
      for (int i = 0; i < NUM_STATUS; i++) snap_q[i] <= stat_arr[i];
    end
  end
`else
  assign stat_val = stat_live;
`endif

  logic        s3_read, s3_dw, s3_half, s3_aerr, s3_derr;
  bank_t       s3_bank;
  logic [5:0]  s3_idx;
  logic [63:0] s3_wdata, s3_stat;

  always_ff @(posedge clock) begin
    if (reset) begin
      s3_v <= 1'b0;
    end else begin
      s3_v <= s2_v;
    end
    s3_read  <= s2_read;
    s3_dw    <= s2_dw;
    s3_half  <= s2_half;
    s3_bank  <= s2_bank;
    s3_idx   <= s2_idx;
    s3_wdata <= s2_wdata;
    s3_aerr  <= s2_aerr;
    s3_derr  <= s2_derr;
    s3_stat  <= stat_val;
  end

  // S3: read mux and write enables; half select 0 = upper word (bits 63:32)
  logic                  wr_ok;
  logic [63:0]           wmask, wval, rd_full, rd_word;
  logic [NUM_CTRL-1:0]   ctrl_we;
  logic [NUM_STICKY-1:0] stky_we;

  always_comb begin
    wr_ok = s3_v & ~s3_read & ~s3_aerr & ~s3_derr;
    wmask = s3_dw ? {64{1'b1}} :
            (s3_half ? {32'd0, {32{1'b1}}} : {{32{1'b1}}, 32'd0});
    wval  = s3_dw ? s3_wdata : {s3_wdata[31:0], s3_wdata[31:0]};
    rd_full = 64'd0;
    case (s3_bank)
      BANK_STAT: rd_full = s3_stat;
      BANK_STKY: begin
        for (int i = 0; i < NUM_STICKY; i++) begin
          if (s3_idx == 6'(i)) rd_full = stky_q[i];
        end
      end
      BANK_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (s3_idx == 6'(i)) rd_full = ctrl_q[i];
        end
      end
      default: rd_full = 64'd0;
    endcase
    if (s3_aerr) rd_full = 64'd0;
    rd_word = s3_dw ? rd_full :
              (s3_half ? {rd_full[31:0], rd_full[31:0]} : {rd_full[63:32], rd_full[63:32]});
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_we[i] = wr_ok && (s3_bank == BANK_CTRL) && (s3_idx == 6'(i));
    end
    for (int i = 0; i < NUM_STICKY; i++) begin
      stky_we[i] = wr_ok && (s3_bank == BANK_STKY) && (s3_idx == 6'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mmio_ack       <= 1'b0;
      mmio_rdata     <= 64'd0;
      mmio_rdata_par <= 1'b1;
      mmio_errors    <= 3'd0;
      ctrl_pulse     <= '0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= 64'd0;
      for (int i = 0; i < NUM_STICKY; i++) stky_q[i] <= 64'd0;
    end else begin
      mmio_ack    <= s3_v;
      mmio_errors <= {ovl, s3_v & s3_derr, s3_v & s3_aerr};
      if (s3_v & s3_read) begin
        mmio_rdata     <= rd_word;
        mmio_rdata_par <= ~^rd_word;
      end
      ctrl_pulse <= ctrl_we;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_we[i]) ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (wval & wmask);
      end
      // Set is OR-ed after the clear so a simultaneous set wins
      for (int i = 0; i < NUM_STICKY; i++) begin
        stky_q[i] <= (stky_q[i] & ~(stky_we[i] ? (wval & wmask) : 64'd0)) |
                     sticky_set[i*64 +: 64];
      end
    end
  end

endmodule

// File: tb/tb_mmio_regfile.sv
// tb/tb_mmio_regfile.sv - scoreboard bench for mmio_regfile with directed MMIO vectors.
module tb_mmio_regfile;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           mmio_valid = 1'b0, mmio_read = 1'b0, mmio_dw = 1'b0;
  logic [23:0]    mmio_addr = '0;
  logic           mmio_addr_par = 1'b0;
  logic [63:0]    mmio_wdata = '0;
  logic           mmio_wdata_par = 1'b0;
  logic [1023:0]  status_in = '0;
  logic [127:0]   sticky_set = '0;
  logic           mmio_ack;
  logic [63:0]    mmio_rdata;
  logic           mmio_rdata_par;
  logic [255:0]   ctrl_out;
  logic [3:0]     ctrl_pulse;
  logic [127:0]   sticky_out;
  logic [2:0]     mmio_errors;

  mmio_regfile dut (
    .clock(clock), .reset(reset), .mmio_valid(mmio_valid), .mmio_read(mmio_read),
    .mmio_dw(mmio_dw), .mmio_addr(mmio_addr), .mmio_addr_par(mmio_addr_par),
    .mmio_wdata(mmio_wdata), .mmio_wdata_par(mmio_wdata_par), .status_in(status_in),
    .sticky_set(sticky_set), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata),
    .mmio_rdata_par(mmio_rdata_par), .ctrl_out(ctrl_out), .ctrl_pulse(ctrl_pulse),
    .sticky_out(sticky_out), .mmio_errors(mmio_errors)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [63:0] rd;
    logic [1:0]  err;
    logic [3:0]  pulse;
    int          chk;
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0, cyc = 0, ovl_cnt = 0;
  logic [63:0] last_rd = 64'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per ack
  always @(negedge clock) begin
    exp_t e;
    if (mmio_errors[2] === 1'b1) ovl_cnt++;
    if (mmio_ack === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_ack: got ack want none");
      end else begin
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.due));
        check("rdata", mmio_rdata, e.rd);
        check("rdata_par", 64'(mmio_rdata_par), 64'(~^e.rd));
        check("errors", 64'(mmio_errors), 64'({1'b0, e.err}));
        check("pulse", 64'(ctrl_pulse), 64'(e.pulse));
        if (e.chk == 1) check("ctrl_out", ctrl_out[e.idx*64 +: 64], e.val);
        else if (e.chk == 2) check("sticky_out", sticky_out[e.idx*64 +: 64], e.val);
      end
    end else if (reset === 1'b0) begin
      check("pulse_idle", 64'(ctrl_pulse), 64'd0);
    end
  end

  task automatic drive(input bit rd, input bit dw, input logic [23:0] a, input logic [63:0] wd,
                       input bit bad_a, input bit bad_d);
    mmio_valid     = 1'b1;
    mmio_read      = rd;
    mmio_dw        = dw;
    mmio_addr      = a;
    mmio_addr_par  = (~^a) ^ bad_a;
    mmio_wdata     = wd;
    mmio_wdata_par = (~^wd) ^ bad_d;
  endtask

  task automatic push(input bit rd, input logic [63:0] xrd, input logic [1:0] xerr,
                      input logic [3:0] xpulse, input int xchk, input int xidx, input logic [63:0] xval);
    exp_t e;
    if (rd) last_rd = xrd;
    e.due = cyc + 4;
    e.rd = last_rd;
    e.err = xerr;
    e.pulse = xpulse;
    e.chk = xchk;
    e.idx = xidx;
    e.val = xval;
    sb.push_back(e);
  endtask

  task automatic req(input bit rd, input bit dw, input logic [23:0] a, input logic [63:0] wd,
                     input bit bad_a, input bit bad_d, input logic [63:0] xrd, input logic [1:0] xerr,
                     input logic [3:0] xpulse, input int xchk, input int xidx, input logic [63:0] xval);
    @(posedge clock); #1;
    drive(rd, dw, a, wd, bad_a, bad_d);
    push(rd, xrd, xerr, xpulse, xchk, xidx, xval);
    @(posedge clock); #1;
    mmio_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int ovl_before;
    status_in[0 +: 64]  = 64'h77;
    status_in[64 +: 64] = 64'h5;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ack", 64'(mmio_ack), 64'd0);
    check("rst_rdata", mmio_rdata, 64'd0);
    check("rst_rdata_par", 64'(mmio_rdata_par), 64'd1);
    check("rst_errors", 64'(mmio_errors), 64'd0);
    check("rst_pulse", 64'(ctrl_pulse), 64'd0);
    check("rst_ctrl", 64'(|ctrl_out), 64'd0);
    check("rst_sticky", 64'(|sticky_out), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // request in flight across reset is dropped
    @(posedge clock); #1 drive(1, 1, 24'h000300, 64'd0, 0, 0);
    @(posedge clock); #1 mmio_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    repeat (5) @(posedge clock);

    // control bank
    req(0, 1, 24'h000302, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 2'b00, 4'b0010, 1, 1, 64'hDEAD_BEEF_0123_4567);
    req(1, 1, 24'h000302, 64'd0, 0, 0, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'b0000, 0, 0, 0);
    req(0, 0, 24'h800300, 64'hAAAA_5555_AAAA_5555, 0, 0, 0, 2'b00, 4'b0001, 1, 0, 64'h0000_0000_AAAA_5555);
    req(1, 0, 24'h000300, 64'd0, 0, 0, 64'h0, 2'b00, 4'b0000, 0, 0, 0);
    req(1, 0, 24'h800300, 64'd0, 0, 0, 64'hAAAA_5555_AAAA_5555, 2'b00, 4'b0000, 0, 0, 0);
    req(1, 1, 24'h000300, 64'd0, 0, 0, 64'h0000_0000_AAAA_5555, 2'b00, 4'b0000, 0, 0, 0);

    // sticky bank: set wins over clear, then clear after set drops
    sticky_set[0 +: 64] = 64'h1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("sticky0_set", sticky_out[0 +: 64], 64'h1);
    req(0, 1, 24'h000200, 64'h1, 0, 0, 0, 2'b00, 4'b0000, 2, 0, 64'h1);
    sticky_set[0 +: 64] = 64'h0;
    req(0, 1, 24'h000200, 64'h1, 0, 0, 0, 2'b00, 4'b0000, 2, 0, 64'h0);
    @(posedge clock); #1 sticky_set[64 +: 64] = 64'hF0;
    @(posedge clock); #1 sticky_set[64 +: 64] = 64'h0;
    @(negedge clock);
    check("sticky1_set", sticky_out[64 +: 64], 64'hF0);
    req(0, 0, 24'h800202, 64'h30_0000_0030, 0, 0, 0, 2'b00, 4'b0000, 2, 1, 64'hC0);
    req(1, 1, 24'h000202, 64'd0, 0, 0, 64'hC0, 2'b00, 4'b0000, 0, 0, 0);

    // parity errors suppress writes but still ack
    req(0, 1, 24'h000300, 64'h1234, 0, 1, 0, 2'b10, 4'b0000, 1, 0, 64'h0000_0000_AAAA_5555);
    req(1, 1, 24'h000302, 64'd0, 1, 0, 64'h0, 2'b01, 4'b0000, 0, 0, 0);
    req(0, 1, 24'h000302, 64'h5, 1, 0, 0, 2'b01, 4'b0000, 1, 1, 64'hDEAD_BEEF_0123_4567);
    req(0, 1, 24'h000100, 64'hFFFF, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0);

    // overlap: second strobe one cycle later is dropped
    ovl_before = ovl_cnt;
    @(posedge clock); #1;
    drive(1, 1, 24'h000302, 64'd0, 0, 0);
    push(1, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'b0000, 0, 0, 0);
    @(posedge clock); #1 drive(1, 1, 24'h000300, 64'd0, 0, 0);
    @(posedge clock); #1 mmio_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("overlap_pulses", 64'(ovl_cnt - ovl_before), 64'd1);

    // unmapped addresses
    req(1, 1, 24'h000101, 64'd0, 0, 0, 64'h0, 2'b00, 4'b0000, 0, 0, 0);
    req(1, 1, 24'h000302, 64'd0, 0, 0, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'b0000, 0, 0, 0);
    req(1, 1, 24'h0FFFF0, 64'd0, 0, 0, 64'h0, 2'b00, 4'b0000, 0, 0, 0);

    // status, with and without snapshot
    req(1, 1, 24'h000100, 64'd0, 0, 0, 64'h77, 2'b00, 4'b0000, 0, 0, 0);
    status_in[64 +: 64] = 64'h9;
`ifdef MMIO_SNAPSHOT_EN
    req(1, 1, 24'h000102, 64'd0, 0, 0, 64'h5, 2'b00, 4'b0000, 0, 0, 0);
`else
    req(1, 1, 24'h000102, 64'd0, 0, 0, 64'h9, 2'b00, 4'b0000, 0, 0, 0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
